uart_rx_pkt_ctrl: RTL and testbench
===================================

# uart_rx_pkt_ctrl

Packet-level receive controller between the byte receiver (`rx_data`/`rx_valid`, one-cycle valid pulse) and the downstream command FSM. It gates the receiver enable, parses frames of the form SYNC, LEN, PAYLOAD[LEN], CHK, and buffers the payload. It releases the payload downstream over a valid/ready stream only after the checksum passes. Malformed, corrupt or stalled frames are discarded and reported through one-cycle error pulses.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `MAX_LEN`, 8, maximum payload bytes; also the buffer depth (1..15).
- `TIMEOUT`, 32, maximum uart_clk cycles allowed between bytes inside a frame (>=2).
- `uart_clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  controller enable.
- `rx_data`  in  8  byte from receiver; valid only while `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `rx_enable`  out  1  enables the byte receiver.
- `pkt_data`  out  8  payload byte.
- `pkt_valid`  out  1  `pkt_data` is valid.
- `pkt_ready`  in  1  downstream accepts.
- `pkt_last`  out  1  marks the final payload byte; qualified by `pkt_valid`.
- `pkt_len`  out  4  LEN of the frame being drained; stable for the whole drain.
- `busy`  out  1  high in any state other than IDLE/SYNC.
- `err_chk`, `err_len`, `err_timeout`  out  1 each  one-cycle error pulses.
- `pkt_count`  out  8  count of fully delivered packets; wraps 255->0.

## Operation
- States: IDLE, SYNC, LEN, PAYLOAD, CHK, DRAIN.
- IDLE:
  - `rx_enable`=0.
  - `enable`=1 -> SYNC.
- SYNC:
  - `rx_enable`=1.
  - Byte == SYNC_BYTE -> LEN. Any other byte is ignored.
  - `enable`=0 -> IDLE.
- LEN:
  - Byte L with 1<=L<=MAX_LEN -> store L, seed running XOR = L, clear the write pointer, go to PAYLOAD.
  - L=0 or L>MAX_LEN -> pulse `err_len`, go to SYNC.
- PAYLOAD:
  - Each byte is written to buf[wptr]; wptr increments and XOR accumulates the byte.
  - After the L-th byte -> CHK.
- CHK:
  - Byte == running XOR -> DRAIN with rptr=0.
  - Otherwise pulse `err_chk`, discard the buffer, go to SYNC.
- DRAIN:
  - `rx_enable`=0; bytes arriving here are ignored.
  - `pkt_data`=buf[rptr], `pkt_valid`=1.
  - On a `pkt_valid`&`pkt_ready` cycle, rptr increments.
  - `pkt_last`=1 when rptr==L-1.
  - Handshake on the last byte -> `pkt_count`+1, go to SYNC (or IDLE if `enable`=0).
- Inter-byte timer:
  - Active in LEN, PAYLOAD and CHK.
  - Cleared on entry to each of these states and on every `rx_valid`; increments otherwise.
  - Reaching TIMEOUT -> pulse `err_timeout`, discard, go to SYNC.
- `enable` falling:
  - In LEN, PAYLOAD or CHK: abort silently (no error pulse), go to IDLE.
  - In DRAIN: the drain completes first, then IDLE.
- Checksum width: 8-bit XOR over LEN and the payload bytes; SYNC is excluded.

## Timing
- Reset values:
  - State = IDLE.
  - All outputs 0: `rx_enable`, `pkt_*`, `busy`, errors, `pkt_count`.
  - Buffer contents need not be reset.
- Reset applies at any state, including mid-frame or mid-drain. A partial packet is lost with no error pulse.
- `rx_valid` is sampled at posedge; the state transition takes effect on that same edge.
- `pkt_valid` rises in the cycle after the edge that sampled a matching CHK byte.
- Streaming:
  - Back-to-back payload bytes run at one per cycle while `pkt_ready`=1.
  - `pkt_data`/`pkt_last` hold stable while `pkt_valid`=1 and `pkt_ready`=0.
- `rx_enable` drops in the same cycle DRAIN is entered. It reasserts the cycle after the last handshake.
- Error pulses are exactly one cycle wide, registered, and asserted in the cycle after the detecting edge.
- `rx_valid` on the same edge the timer would reach TIMEOUT: the byte wins and the timer clears.
- `busy`=1 in LEN, PAYLOAD, CHK and DRAIN.

## Test plan
- Good frame A5 03 11 22 33 03, `pkt_ready`=1:
  - Outputs 11, 22, 33 on consecutive cycles; `pkt_last` only with 33; `pkt_len`=3.
  - `pkt_count` 0->1; `rx_enable` low throughout the drain.
- Noise then frame:
  - Bytes 00 FF then A5 01 7E 7F -> single byte 7E delivered.
  - Frame A5 02 10 20 31 (bad CHK, expected 32) -> `err_chk` one pulse, no `pkt_valid`, `pkt_count` unchanged.
- Length errors:
  - A5 00 -> `err_len` pulse.
  - A5 09 with MAX_LEN=8 -> `err_len` pulse.
  - Following A5 01 55 54 still delivers 55.
- Timeout: A5 04 AA BB then silence -> `err_timeout` exactly TIMEOUT cycles after the BB strobe; state returns to SYNC.
- Back-pressure: good 3-byte frame with `pkt_ready` low for 5 cycles on byte 2 -> `pkt_data` is held; no byte lost or duplicated.
- Reset/enable mid-frame:
  - `rst_n`=0 during PAYLOAD -> all outputs 0 next cycle, no error pulse.
  - `enable` low during DRAIN -> drain completes, then IDLE with `rx_enable`=0.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl_if.sv
// Payload stream from the packet controller to the downstream command FSM.
// The master drives data/valid/last/len; the slave returns ready.
interface uart_rx_pkt_ctrl_if;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic [3:0] pkt_len;

    modport master (
        output pkt_data,
        output pkt_valid,
        output pkt_last,
        output pkt_len,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        input  pkt_last,
        input  pkt_len,
        output pkt_ready
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Frame parser between the UART byte receiver and the command FSM: SYNC, LEN,
// PAYLOAD[LEN], CHK; the payload is buffered and released only after the XOR checksum matches.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | controller disabled, receiver gated off
// SYNC    | hunting for the sync byte, all other bytes dropped
// LEN     | waiting for the length byte
// PAYLOAD | storing payload bytes into the buffer
// CHK     | waiting for the checksum byte
// DRAIN   | releasing the buffered payload downstream, receiver gated off
module uart_rx_pkt_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 8,
    parameter int unsigned TIMEOUT   = 32
) (
    input  logic                      uart_clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    output logic                      rx_enable_o,
    uart_rx_pkt_ctrl_if.master        pkt_if,
    output logic                      busy_o,
    output logic                      err_chk_o,
    output logic                      err_len_o,
    output logic                      err_timeout_o,
    output logic [7:0]                pkt_count_o
);

    localparam int unsigned   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned   TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [3:0]    len_q, len_d;
    logic [7:0]    xor_q, xor_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_chk_q, err_chk_d;
    logic          err_len_q, err_len_d;
    logic          err_to_q, err_to_d;
    logic [7:0]    mem_q [0:MAX_LEN-1];

    logic          wr_en;
    logic          drain;
    logic          last_beat;
    logic [AW-1:0] last_idx;

    assign last_idx  = AW'(len_q - 4'd1);
    assign drain     = (state_q == S_DRAIN);
    assign last_beat = drain && (rptr_q == last_idx);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        xor_d     = xor_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        tmr_d     = TMR_LOAD;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        wr_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_SYNC;
            end

            S_SYNC: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end

            S_LEN, S_PAYLOAD, S_CHK: begin
                // Disable aborts silently; a byte on the terminal-count edge beats the timeout.
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (rx_valid_i) begin
                    if (state_q == S_LEN) begin
                        if ((rx_data_i != 8'h00) && (rx_data_i <= MAX_LEN_B)) begin
                            len_d   = rx_data_i[3:0];
                            xor_d   = rx_data_i;
                            wptr_d  = '0;
                            state_d = S_PAYLOAD;
                        end else begin
                            err_len_d = 1'b1;
                            state_d   = S_SYNC;
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        wr_en = 1'b1;
                        xor_d = xor_q ^ rx_data_i;
                        if (wptr_q == last_idx) begin
                            state_d = S_CHK;
                        end else begin
                            wptr_d = wptr_q + 1'b1;
                        end
                    end else begin
                        if (rx_data_i == xor_q) begin
                            rptr_d  = '0;
                            state_d = S_DRAIN;
                        end else begin
                            err_chk_d = 1'b1;
                            state_d   = S_SYNC;
                        end
                    end
                end else if (tmr_q == '0) begin
                    err_to_d = 1'b1;
                    state_d  = S_SYNC;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            S_DRAIN: begin
                // pkt_valid is constant high here, so ready alone completes a beat.
                if (pkt_if.pkt_ready) begin
                    if (last_beat) begin
                        cnt_d   = cnt_q + 8'd1;
                        rptr_d  = '0;
                        state_d = enable_i ? S_SYNC : S_IDLE;
                    end else begin
                        rptr_d = rptr_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            xor_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            tmr_q     <= TMR_LOAD;
            cnt_q     <= '0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            xor_q     <= xor_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
        end
    end

    // Payload buffer carries no reset; stale contents are masked off outside DRAIN.
    always_ff @(posedge uart_clk) begin
        if (wr_en) mem_q[wptr_q] <= rx_data_i;
    end

    assign rx_enable_o = (state_q == S_SYNC) || (state_q == S_LEN) ||
                         (state_q == S_PAYLOAD) || (state_q == S_CHK);
    assign busy_o      = (state_q == S_LEN) || (state_q == S_PAYLOAD) ||
                         (state_q == S_CHK) || drain;

    assign pkt_if.pkt_valid = drain;
    assign pkt_if.pkt_data  = drain ? mem_q[rptr_q] : 8'h00;
    assign pkt_if.pkt_last  = last_beat;
    assign pkt_if.pkt_len   = drain ? len_q : 4'd0;

    assign err_chk_o     = err_chk_q;
    assign err_len_o     = err_len_q;
    assign err_timeout_o = err_to_q;
    assign pkt_count_o   = cnt_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: expected payload beats go into a scoreboard
// queue as frames are sent and are popped by a negedge monitor on each handshake.
module tb_uart_rx_pkt_ctrl;

    localparam int TO = 32;

    logic       uart_clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_enable;
    logic       busy;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic [7:0] pkt_count;

    uart_rx_pkt_ctrl_if pif ();

    uart_rx_pkt_ctrl #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (8),
        .TIMEOUT   (TO)
    ) dut (
        .uart_clk      (uart_clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rx_enable_o   (rx_enable),
        .pkt_if        (pif),
        .busy_o        (busy),
        .err_chk_o     (err_chk),
        .err_len_o     (err_len),
        .err_timeout_o (err_timeout),
        .pkt_count_o   (pkt_count)
    );

    initial uart_clk = 1'b0;
    always #5 uart_clk = ~uart_clk;

    int tests = 0;
    int fails = 0;
    int n_chk = 0;
    int n_len = 0;
    int n_to  = 0;
    logic [7:0]  exp_count = 8'd0;
    logic [12:0] sb [$];
    logic [12:0] e;
    logic        stall_q = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    logic        hold_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge uart_clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic last, input logic [3:0] len);
        sb.push_back({len, last, d});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge uart_clk); #1;
        end
    endtask

    task automatic wait_drain(input string tag, input int exp_cyc);
        int c;
        c = 0;
        while ((sb.size() != 0 || pif.pkt_valid) && c < 200) begin
            @(posedge uart_clk); #1;
            c++;
        end
        check(tag, 32'(c), 32'(exp_cyc));
    endtask

    always @(negedge uart_clk) begin
        if (rst_n) begin
            if (pif.pkt_valid) begin
                check("rx_en_in_drain", 32'(rx_enable), 32'd0);
                if (stall_q) begin
                    check("hold_data", 32'(pif.pkt_data), 32'(hold_data));
                    check("hold_last", 32'(pif.pkt_last), 32'(hold_last));
                end
                if (pif.pkt_ready) begin
                    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("pkt_data", 32'(pif.pkt_data), 32'(e[7:0]));
                        check("pkt_last", 32'(pif.pkt_last), 32'(e[8]));
                        check("pkt_len",  32'(pif.pkt_len),  32'(e[12:9]));
                    end
                end
            end
            stall_q   = pif.pkt_valid && !pif.pkt_ready;
            hold_data = pif.pkt_data;
            hold_last = pif.pkt_last;
            if (err_chk)     n_chk++;
            if (err_len)     n_len++;
            if (err_timeout) n_to++;
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, l0, t0, k;
        rst_n         = 1'b0;
        enable        = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        pif.pkt_ready = 1'b1;
        step(3);

        // Reset state
        check("rst_rx_enable", 32'(rx_enable), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_valid",     32'(pif.pkt_valid), 32'd0);
        check("rst_data",      32'(pif.pkt_data), 32'd0);
        check("rst_last",      32'(pif.pkt_last), 32'd0);
        check("rst_len",       32'(pif.pkt_len), 32'd0);
        check("rst_errs",      32'({err_chk, err_len, err_timeout}), 32'd0);
        check("rst_count",     32'(pkt_count), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        step(1);
        check("sync_rx_enable", 32'(rx_enable), 32'd1);
        check("sync_busy",      32'(busy), 32'd0);

        // Good frame A5 03 11 22 33 03
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33);
        check("chk_state_busy", 32'(busy), 32'd1);
        check("no_valid_before_chk", 32'(pif.pkt_valid), 32'd0);
        push_exp(8'h11, 1'b0, 4'd3); push_exp(8'h22, 1'b0, 4'd3); push_exp(8'h33, 1'b1, 4'd3);
        send_byte(8'h03);
        check("valid_after_chk", 32'(pif.pkt_valid), 32'd1);
        check("rx_en_drop",      32'(rx_enable), 32'd0);
        wait_drain("drain_cycles_3", 3);
        exp_count++;
        check("count_after_a", 32'(pkt_count), 32'(exp_count));
        check("rx_en_reassert", 32'(rx_enable), 32'd1);

        // Noise then single-byte frame
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E);
        push_exp(8'h7E, 1'b1, 4'd1);
        send_byte(8'h7F);
        wait_drain("drain_cycles_1", 1);
        exp_count++;
        check("count_after_noise", 32'(pkt_count), 32'(exp_count));

        // Bad checksum
        c0 = n_chk;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
        send_byte(8'h31);
        check("err_chk_pulse", 32'(err_chk), 32'd1);
        check("bad_chk_no_valid", 32'(pif.pkt_valid), 32'd0);
        step(1);
        check("err_chk_width", 32'(err_chk), 32'd0);
        step(3);
        check("err_chk_count", 32'(n_chk - c0), 32'd1);
        check("count_after_bad", 32'(pkt_count), 32'(exp_count));

        // Length errors, then recovery
        l0 = n_len;
        send_byte(8'hA5); send_byte(8'h00);
        check("err_len_zero", 32'(err_len), 32'd1);
        send_byte(8'hA5); send_byte(8'h09);
        check("err_len_big", 32'(err_len), 32'd1);
        step(2);
        check("err_len_count", 32'(n_len - l0), 32'd2);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55);
        push_exp(8'h55, 1'b1, 4'd1);
        send_byte(8'h54);
        wait_drain("drain_after_len_err", 1);
        exp_count++;
        check("count_after_len", 32'(pkt_count), 32'(exp_count));

        // Timeout exactly TO cycles after the last strobe
        t0 = n_to;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
        k = 0;
        do begin
            step(1);
            k++;
        end while (!err_timeout && k < 100);
        check("timeout_latency", 32'(k), 32'(TO));
        check("timeout_to_sync_busy", 32'(busy), 32'd0);
        check("timeout_to_sync_rxen", 32'(rx_enable), 32'd1);
        step(2);
        check("timeout_count", 32'(n_to - t0), 32'd1);

        // Byte arriving on the terminal-count edge wins
        t0 = n_to;
        send_byte(8'hA5); send_byte(8'h02);
        step(TO - 1);
        send_byte(8'hC3); send_byte(8'h3C);
        push_exp(8'hC3, 1'b0, 4'd2); push_exp(8'h3C, 1'b1, 4'd2);
        send_byte(8'hFD);
        wait_drain("drain_after_gap", 2);
        exp_count++;
        check("gap_no_timeout", 32'(n_to - t0), 32'd0);
        check("count_after_gap", 32'(pkt_count), 32'(exp_count));

        // Back-pressure on byte 2
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        push_exp(8'h01, 1'b0, 4'd3); push_exp(8'h02, 1'b0, 4'd3); push_exp(8'h03, 1'b1, 4'd3);
        send_byte(8'h03);
        step(1);
        pif.pkt_ready = 1'b0;
        step(5);
        check("bp_data_held",  32'(pif.pkt_data), 32'h02);
        check("bp_valid_held", 32'(pif.pkt_valid), 32'd1);
        pif.pkt_ready = 1'b1;
        wait_drain("drain_after_bp", 2);
        exp_count++;
        check("count_after_bp", 32'(pkt_count), 32'(exp_count));

        // Reset mid-payload
        c0 = n_chk; l0 = n_len; t0 = n_to;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        rst_n = 1'b0;
        step(1);
        exp_count = 8'd0;
        check("midrst_outputs", 32'({rx_enable, busy, pif.pkt_valid, err_chk, err_len, err_timeout}), 32'd0);
        check("midrst_count", 32'(pkt_count), 32'(exp_count));
        rst_n = 1'b1;
        step(2);
        check("midrst_no_err", 32'((n_chk - c0) + (n_len - l0) + (n_to - t0)), 32'd0);
        check("midrst_resync", 32'(rx_enable), 32'd1);

        // Enable drop mid-payload aborts silently
        t0 = n_to; c0 = n_chk;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        enable = 1'b0;
        step(1);
        check("abort_rx_enable", 32'(rx_enable), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        step(TO + 8);
        check("abort_no_err", 32'((n_to - t0) + (n_chk - c0)), 32'd0);
        enable = 1'b1;
        step(1);

        // Enable drop during drain: drain completes, then IDLE
        pif.pkt_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
        push_exp(8'hAB, 1'b0, 4'd2); push_exp(8'hCD, 1'b1, 4'd2);
        send_byte(8'h64);
        enable = 1'b0;
        step(3);
        check("en_drain_valid", 32'(pif.pkt_valid), 32'd1);
        check("en_drain_data",  32'(pif.pkt_data), 32'hAB);
        pif.pkt_ready = 1'b1;
        wait_drain("drain_en_low", 2);
        exp_count++;
        check("en_drain_count", 32'(pkt_count), 32'(exp_count));
        check("en_drain_idle_rxen", 32'(rx_enable), 32'd0);
        check("en_drain_idle_busy", 32'(busy), 32'd0);
        step(3);
        check("idle_stays_off", 32'(rx_enable), 32'd0);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
